// File: rtl/dm_banked_ctrl.sv
// dm_banked_ctrl: data memory with byte-lane stores, extended sub-word loads and a
// req/ready/rvalid handshake; an optional post-reset sweep zeroes the array.
module dm_banked_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int LATENCY        = 0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] pc_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;

    state_e            state_q;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ptr_q;
    logic [3:0]        cnt_q;
    logic [31:0]       addr_q, wdata_q, pc_q, wword_q, rdata_q;
    logic [1:0]        size_q;
    logic              we_q, sx_q, ready_q, rvalid_q, err_q;
    logic              idle, accept, go_resp, bad, c_we, c_sx;
    logic [31:0]       c_addr, c_wdata, old_w, rep, merged, ld;
    logic [1:0]        c_size;
    logic [3:0]        be;
    logic [7:0]        lb;
    logic [15:0]       lh;

    assign idle    = state_q == IDLE;
    assign accept  = idle && ready_q && req_i;
    assign go_resp = (accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd0);

    // While idle the live inputs are the request being accepted, so a zero-latency
    // access can form its response on the accepting edge.
    always_comb begin
        c_addr  = idle ? addr_i : addr_q;
        c_wdata = idle ? wdata_i : wdata_q;
        c_size  = idle ? size_i : size_q;
        c_we    = idle ? we_i : we_q;
        c_sx    = idle ? sign_ext_i : sx_q;
        bad     = c_size == 2'd3 || (c_size == 2'd1 && c_addr[0]) ||
                  (c_size == 2'd2 && c_addr[1:0] != 2'b00) || c_addr[31:ADDR_W+2] != '0;
        old_w   = mem[c_addr[ADDR_W+1:2]];
        be      = c_size == 2'd0 ? 4'b0001 << c_addr[1:0] :
                  c_size == 2'd1 ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        rep     = c_size == 2'd0 ? {4{c_wdata[7:0]}} :
                  c_size == 2'd1 ? {2{c_wdata[15:0]}} : c_wdata;
        merged  = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
        lb      = old_w[{c_addr[1:0], 3'b000} +: 8];
        lh      = c_addr[1] ? old_w[31:16] : old_w[15:0];
        ld      = c_size == 2'd0 ? {{24{c_sx & lb[7]}}, lb} :
                  c_size == 2'd1 ? {{16{c_sx & lh[15]}}, lh} : old_w;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= CLEAR_ON_RESET ? INIT : IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wword_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            pc_q     <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            sx_q     <= 1'b0;
        end else begin
            rvalid_q <= go_resp;
            err_q    <= go_resp && bad;
            rdata_q  <= go_resp && !bad && !c_we ? ld : '0;
            if (go_resp) wword_q <= merged;
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == '1) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                IDLE: begin
                    ready_q <= !accept;
                    if (accept) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        pc_q    <= pc_i;
                        size_q  <= size_i;
                        we_q    <= we_i;
                        sx_q    <= sign_ext_i;
                        state_q <= LATENCY > 0 ? WAIT : RESP;
                        cnt_q   <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == 4'd0) state_q <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Array port: sweep writes during INIT, committed stores on the edge leaving RESP.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) mem[ptr_q] <= '0;
        else if (state_q == RESP && we_q && !err_q) begin
            mem[addr_q[ADDR_W+1:2]] <= wword_q;
            $display("%d@%h: *%h <= %h", $time, pc_q, {addr_q[31:2], 2'b00}, wword_q);
        end
    end

    assign ready_o  = ready_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_dm_banked_ctrl.sv
// tb_dm_banked_ctrl: randomized accesses on two configurations checked against a
// byte-level reference memory model.
module tb_dm_banked_ctrl;
    localparam int LAT [2] = '{2, 0};

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [1:0]       req = '0, we = '0, sx = '0, ready, rvalid, err;
    logic [1:0][31:0] addr = '0, wdata = '0, pc = '0, rdata;
    logic [1:0][1:0]  size = '0;
    logic [31:0]      mem_m [2][16];
    logic [31:0]      got;
    int               total = 0, bad = 0;

    always #5 clk = ~clk;

    dm_banked_ctrl #(.ADDR_W(4), .LATENCY(2), .CLEAR_ON_RESET(1'b1)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .size_i(size[0]), .sign_ext_i(sx[0]), .wdata_i(wdata[0]), .pc_i(pc[0]),
        .ready_o(ready[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    dm_banked_ctrl #(.ADDR_W(4), .LATENCY(0), .CLEAR_ON_RESET(1'b0)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .size_i(size[1]), .sign_ext_i(sx[1]), .wdata_i(wdata[1]), .pc_i(pc[1]),
        .ready_o(ready[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: bytes are copied lane by lane, loads are shifted/masked/extended arithmetically.
    function automatic void model(input int k, input bit w, input logic [31:0] a,
                                  input logic [1:0] s, input bit x, input logic [31:0] d,
                                  output logic [31:0] er, output logic ee);
        int nb, wi, off;
        logic [31:0] v, mask;
        nb = 1 << s;
        ee = s == 2'd3 || (a % nb) != 0 || a >= 64;
        er = '0;
        if (ee) return;
        wi = int'(a >> 2);
        off = int'(a % 4);
        if (w) begin
            for (int b = 0; b < nb; b++) mem_m[k][wi][8*(off+b) +: 8] = d[8*b +: 8];
        end else begin
            mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8*nb)) - 1;
            v = (mem_m[k][wi] >> (8*off)) & mask;
            if (x && v[8*nb-1]) v = v | ~mask;
            er = v;
        end
    endfunction

    task automatic acc(input int k, input bit w, input logic [31:0] a, input logic [1:0] s,
                       input bit x, input logic [31:0] d, output logic [31:0] r);
        int n;
        logic [31:0] er;
        logic ee;
        n = 0;
        r = '0;
        while (!ready[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) begin
            check("ready_timeout", 32'(ready[k]), 32'd1);
            return;
        end
        req[k] = 1'b1; we[k] = w; addr[k] = a; size[k] = s; sx[k] = x; wdata[k] = d;
        pc[k] = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0; addr[k] = $urandom; wdata[k] = $urandom; size[k] = 2'($urandom);
        n = 1;
        while (!rvalid[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(LAT[k] + 1));
        model(k, w, a, s, x, d, er, ee);
        check("err", 32'(err[k]), 32'(ee));
        check("rdata", rdata[k], er);
        r = rdata[k];
        @(negedge clk);
        check("rvalid_pulse", 32'(rvalid[k]), 32'd0);
        check("rdata_idle", rdata[k], 32'd0);
    endtask

    task automatic reset_and_sweep(input int cyc);
        int n0, n1, rv;
        rst_n = 1'b0;
        repeat (cyc) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", 32'(ready[k]), 32'd0);
            check("rst_rvalid", 32'(rvalid[k]), 32'd0);
            check("rst_rdata", rdata[k], 32'd0);
            check("rst_err", 32'(err[k]), 32'd0);
        end
        rst_n = 1'b1;
        n0 = 0; n1 = 0; rv = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ready[0] && n0 == 0) n0 = c;
            if (ready[1] && n1 == 0) n1 = c;
            rv += int'(rvalid[0]) + int'(rvalid[1]);
        end
        check("sweep_ready", 32'(n0), 32'd16);
        check("noclear_ready", 32'(n1), 32'd1);
        check("no_rvalid", 32'(rv), 32'd0);
        for (int i = 0; i < 16; i++) mem_m[0][i] = '0;
    endtask

    initial begin
        reset_and_sweep(3);
        for (int i = 0; i < 16; i++) acc(1, 1'b1, 32'(i * 4), 2'd2, 1'b0, $urandom, got);

        acc(0, 1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, got);         check("ld_3c", got, 32'h0);
        acc(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'h11223344, got);
        acc(0, 1'b0, 32'h13, 2'd0, 1'b0, 32'h0, got);         check("ldb_13", got, 32'h11);
        acc(0, 1'b0, 32'h12, 2'd1, 1'b0, 32'h0, got);         check("ldh_12", got, 32'h1122);
        acc(0, 1'b1, 32'h11, 2'd0, 1'b0, 32'hAB, got);
        acc(0, 1'b0, 32'h11, 2'd0, 1'b1, 32'h0, got);         check("ldb_11_sx", got, 32'hFFFFFFAB);
        acc(0, 1'b0, 32'h11, 2'd0, 1'b0, 32'h0, got);         check("ldb_11_zx", got, 32'hAB);
        acc(0, 1'b1, 32'h13, 2'd1, 1'b0, 32'h5555, got);
        acc(0, 1'b0, 32'h12, 2'd2, 1'b0, 32'h0, got);
        acc(0, 1'b0, 32'h10, 2'd3, 1'b0, 32'h0, got);
        acc(0, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, got);
        acc(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, got);         check("word_10", got, 32'h1122AB44);

        for (int i = 0; i < 200; i++)
            acc(int'($urandom_range(0, 1)), 1'($urandom), 32'($urandom_range(0, 'h47)),
                2'($urandom), 1'($urandom), $urandom, got);

        acc(1, 1'b1, 32'h8, 2'd2, 1'b0, 32'hDEADBEEF, got);

        // Abort a store in flight on u0 one cycle after acceptance.
        check("abort_ready", 32'(ready[0]), 32'd1);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; size[0] = 2'd2; wdata[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        reset_and_sweep(2);
        acc(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0, got);         check("ld_20_after_abort", got, 32'h0);
        acc(1, 1'b0, 32'h8, 2'd2, 1'b0, 32'h0, got);          check("ld_8_retained", got, 32'hDEADBEEF);

        for (int i = 0; i < 60; i++)
            acc(int'($urandom_range(0, 1)), 1'($urandom), 32'($urandom_range(0, 'h47)),
                2'($urandom), 1'($urandom), $urandom, got);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
